// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: default word width and a pure bin-to-Gray conversion.
// Latency: none (constants and a combinational function only).
// Backpressure: not applicable; nothing in this package holds state.
package gray_pkg;

    // Default width of count and code words.
    localparam int GRAY_DEFAULT_WIDTH = 4;

    // Widest word the helper function accepts. Callers zero-extend narrower
    // words and keep the low bits of the result. A zero-extended input
    // converts correctly because the top bit of the result is bin[msb] ^ 0.
    localparam int GRAY_MAX_WIDTH = 64;

    typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

    // Reflected binary Gray code: each bit is the XOR of itself and its
    // more-significant neighbour.
    function automatic gray_word_t bin_to_gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary to reflected-Gray converter.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the output follows the input continuously.
//
// Ports:
//   bin  - binary word in
//   gray - Gray-code image of bin
module bin2gray
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Each output bit differs from the input bit by its left neighbour;
    // the MSB has no neighbour and passes straight through.
    always_comb begin
        gray = bin ^ (bin >> 1);
    end

endmodule

// File: rtl/bin2gray_counter.sv
// Up/down binary counter with a registered Gray-code image and a wrap pulse.
// Latency: one clock edge from load/en to bin, gray and wrap.
// Backpressure: none; en is a plain enable, and the count holds while en and load are low.
//
// Ports:
//   clk      - clock; all state updates happen on its rising edge
//   rst      - synchronous active-high reset (highest priority)
//   en       - count enable, one step per enabled edge
//   up       - direction: 1 increments, 0 decrements
//   load     - synchronous load strobe (beats en)
//   load_bin - binary value captured on load
//   bin      - registered binary count
//   gray     - registered Gray image of bin, updated on the same edge as bin
//   wrap     - registered one-cycle pulse after a max->0 or 0->max count step
module bin2gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = '0;

    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;

    // Next binary value. Load outranks the count step, and an idle cycle
    // leaves bin_nxt equal to bin, so the registers below simply reload
    // their own value.
    always_comb begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
        if (load) begin
            // A loaded value never reports a wrap, even when it is 0 or max.
            bin_nxt = load_bin;
        end else if (en) begin
            if (up) begin
                bin_nxt  = bin + CNT_ONE;
                wrap_nxt = (bin == CNT_MAX);
            end else begin
                bin_nxt  = bin - CNT_ONE;
                wrap_nxt = (bin == CNT_MIN);
            end
        end
    end

    // The Gray code is taken from the next binary value, not from the bin
    // register. The gray and bin registers therefore load on the same edge
    // with no skew between them.
    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (bin_nxt),
        .gray (gray_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
            // wrap_nxt is low on every non-wrapping cycle, so the pulse
            // lasts exactly one cycle.
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_bin2gray_counter.sv
module tb_bin2gray_counter;

    localparam int W    = 4;
    localparam int MODV = 2 ** W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;

    always #5 clk = ~clk;

    bin2gray_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap)
    );

    typedef struct {
        logic [W-1:0] bin;
        logic [W-1:0] gray;
        logic         wrap;
        logic         step;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: the count as a plain integer in 0..MODV-1.
    int mcount = 0;

    // Gray code sequence for 4 bits, listed by binary index.
    int gray_tbl[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    // Gray-to-binary decoder: each binary bit is the parity of all Gray
    // bits at or above it.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        logic         acc;
        acc = 1'b0;
        b   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, and post the expected
    // outputs after the edge.
    task automatic step(input logic r, input logic e, input logic u,
                        input logic l, input logic [W-1:0] lb);
        exp_t x;
        logic w;
        w        = 1'b0;
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_bin = lb;
        if (r) begin
            mcount = 0;
        end else if (l) begin
            mcount = int'(lb);
        end else if (e) begin
            if (u) begin
                w      = (mcount == MODV - 1);
                mcount = (mcount + 1) % MODV;
            end else begin
                w      = (mcount == 0);
                mcount = (mcount + MODV - 1) % MODV;
            end
        end
        x.bin  = W'(mcount);
        x.gray = W'(gray_tbl[mcount]);
        x.wrap = w;
        x.step = !r && !l && e;
        @(posedge clk);
        q.push_back(x);
        #1;
    endtask

    // Monitor: the outputs are valid every cycle, so compare at each falling
    // edge against whatever the driver has posted.
    exp_t         mx;
    logic [W-1:0] prev_gray;
    logic         have_prev = 1'b0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mx = q.pop_front();
            chk("bin", int'(bin), int'(mx.bin));
            chk("gray", int'(gray), int'(mx.gray));
            chk("wrap", int'(wrap), int'(mx.wrap));
            chk("gray2bin_roundtrip", int'(gray2bin(gray)), int'(bin));
            if (mx.step && have_prev)
                chk("gray_one_bit_step", $countones(gray ^ prev_gray), 1);
            prev_gray = gray;
            have_prev = 1'b1;
        end
    end

    initial begin
        // Reset overrides load and en, and holds while rst stays high.
        step(1, 1, 1, 1, 4'h5);
        step(1, 1, 0, 1, 4'hA);

        // Full up-count through all 16 codes, with the wrap on the last step.
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 4'h0);
        step(0, 0, 1, 0, 4'h0);                  // hold; wrap drops

        // Load, then count down.
        step(0, 0, 1, 1, 4'hC);
        step(0, 1, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'h0);

        // Down wrap from 0 to max.
        step(0, 0, 0, 1, 4'h0);
        step(0, 1, 0, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);

        // Simultaneous load and en: the load wins.
        step(0, 1, 1, 1, 4'h3);

        // Loads onto max and 0 must not pulse wrap.
        step(0, 1, 1, 1, 4'hF);
        step(0, 1, 0, 1, 4'h0);

        // Reset in the middle of a count, then resume from 0.
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 4'h0);
        step(1, 1, 1, 0, 4'h0);
        step(0, 1, 1, 0, 4'h0);
        step(0, 1, 0, 0, 4'h0);

        // Random traffic, with direction changes on any cycle.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(31) == 0),
                 ($urandom_range(3) != 0),
                 1'($urandom_range(1)),
                 ($urandom_range(7) == 0),
                 W'($urandom_range(MODV - 1)));
        end
        step(0, 0, 1, 0, 4'h0);

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2gray_counter.md
BIN2GRAY_COUNTER -- requirements
Module: bin2gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the bit width of the count and code words (minimum 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port en  input  1  count enable; advances the count by one step when high.
REQ-005 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port load  input  1  synchronous load strobe.
REQ-007 SHALL have port load_bin  input  WIDTH  binary value captured when load is high.
REQ-008 SHALL have port bin  output  WIDTH  registered binary count.
REQ-009 SHALL have port gray  output  WIDTH  registered Gray-code image of bin.
REQ-010 SHALL have port wrap  output  1  registered one-cycle pulse marking a counter wrap-around.

Function
REQ-011 SHALL apply priority at each rising edge: rst, then load, then en, then hold.
REQ-012 SHALL, on load, set bin = load_bin and gray = load_bin ^ (load_bin >> 1) at that same edge; en and up are ignored that cycle.
REQ-013 SHALL, on en without load, set bin = bin + 1 when up = 1 and bin = bin - 1 when up = 0, both modulo 2^WIDTH.
REQ-014 SHALL hold bin, gray and the internal state when en = 0 and load = 0.
REQ-015 SHALL compute gray from the next binary value and register it, so gray always equals bin ^ (bin >> 1) with zero cycles of skew between the two outputs.
REQ-016 SHALL produce an output-to-register latency of exactly one edge for load and count operations.
REQ-017 SHALL change exactly one bit of gray for every count step, including both wrap-around steps (max to 0 and 0 to max).
REQ-018 SHALL assert wrap for exactly the one cycle after an edge where en = 1, load = 0, up = 1 and bin = 2^WIDTH-1.
REQ-019 SHALL also assert wrap for exactly the one cycle after an edge where en = 1, load = 0, up = 0 and bin = 0.
REQ-020 SHALL keep wrap low after a load, even when load_bin lands on 0 or the maximum value.
REQ-021 SHALL allow up to change on any cycle, with the new direction taking effect at the next enabled edge.
REQ-022 SHALL have no combinational path from any input to any output.

Reset
REQ-023 SHALL, with rst high at an edge, force bin = 0, gray = 0 and wrap = 0, overriding load and en.
REQ-024 SHALL hold those reset values for every edge at which rst stays high.
REQ-025 SHALL abandon any in-progress count when rst is asserted mid-sequence; counting resumes from 0 at the first enabled edge after release.

Structure
REQ-026 SHALL place the default width constant (4) and a pure bin-to-Gray conversion function in the shared package gray_pkg, for reuse by the existing Gray-to-binary decoder's benches.
REQ-027 SHALL instantiate one combinational sub-module, bin2gray (parameter WIDTH; ports bin in, gray out), on the next-count path.
REQ-028 SHALL keep all sequential logic in bin2gray_counter itself.

Verification
REQ-029 SHALL cover reset: rst = 1 with en = 1 and load = 1 -> bin = 0, gray = 0, wrap = 0 after the edge.
REQ-030 SHALL cover the full up-count: up = 1, en = 1 for 16 cycles from 0 -> gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0, with wrap high only in the cycle after 8 returns to 0.
REQ-031 SHALL cover load and down-count: load_bin = 4'hC, then up = 0 with en = 1 -> bin C,B,A; gray A,E,F.
REQ-032 SHALL cover down wrap: load 0, then en = 1, up = 0 -> bin = F, gray = 8, wrap = 1 for one cycle.
REQ-033 SHALL cover simultaneous load and en: load = 1 with load_bin = 4'h3 and en = 1 -> bin = 3, gray = 2, no increment and wrap = 0.
REQ-034 SHALL cover the round-trip check: feed gray through the existing gray2bin decoder for all 16 codes -> decoded value equals bin on every cycle, and gray changes by exactly one bit per step.
